// File: rtl/lfsr_period_checker_if.sv
// Bundle between an LFSR stage (plus its controller) and the period checker.
//   master : drives clear, in_valid, lfsr_q, max_tick; observes the status outputs
//   slave  : the checker; consumes the samples and drives the status outputs
//   clear      restart measurement (synchronous)
//   in_valid   lfsr_q/max_tick carry a freshly shifted state this cycle
//   lfsr_q     LFSR state word
//   max_tick   LFSR period strobe
//   period_ok  at least one good period measured and no fault
//   err        sticky fault flag
//   err_code   first fault: 0 none, 1 lockup, 2 stuck, 3 short, 4 long, 5 tick
//   period_cnt last completed measured period length
//   pass_cnt   good periods seen, saturating at 255
//   busy       measurement in progress
interface lfsr_period_checker_if #(
  parameter int unsigned WIDTH = 12
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] lfsr_q;
  logic             max_tick;
  logic             period_ok;
  logic             err;
  logic [2:0]       err_code;
  logic [WIDTH-1:0] period_cnt;
  logic [7:0]       pass_cnt;
  logic             busy;

  modport master (
    output clear, in_valid, lfsr_q, max_tick,
    input  period_ok, err, err_code, period_cnt, pass_cnt, busy
  );

  modport slave (
    input  clear, in_valid, lfsr_q, max_tick,
    output period_ok, err, err_code, period_cnt, pass_cnt, busy
  );
endinterface

// File: rtl/lfsr_period_checker.sv
// Monitors an XNOR LFSR stream and confirms it is maximal length: the first
// sample after reset/clear becomes the reference, and the stream must return to
// it after exactly PERIOD samples, with max_tick marking that return. Lockup,
// stuck, short-period, long-period and misaligned-tick faults are latched.
//   clk   system clock, rising edge
//   reset asynchronous, active-high; clears all state
//   bus   lfsr_period_checker_if slave modport (samples in, status out)
module lfsr_period_checker #(
  parameter int unsigned     WIDTH      = 12,
  parameter int unsigned     PERIOD     = 4095,
  parameter logic [WIDTH-1:0] LOCKUP    = '1,
  parameter bit              CHECK_TICK = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  lfsr_period_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFail} state_e;

  typedef enum logic [2:0] {
    ErrNone   = 3'd0,
    ErrLockup = 3'd1,
    ErrStuck  = 3'd2,
    ErrShort  = 3'd3,
    ErrLong   = 3'd4,
    ErrTick   = 3'd5
  } err_e;

  localparam logic [WIDTH-1:0] PeriodW = WIDTH'(PERIOD);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             period_ok_q, period_ok_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;
  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;

  logic [WIDTH-1:0] cnt_next;
  logic             at_ref;
  err_e             run_fault;

  assign cnt_next = cnt_q + WIDTH'(1);
  assign at_ref   = (bus.lfsr_q == ref_q);

  // Highest-priority fault for a sample taken in StRun.
  always_comb begin
    run_fault = ErrNone;
    if (bus.lfsr_q == LOCKUP) begin
      run_fault = ErrLockup;
    end else if (bus.lfsr_q == prev_q) begin
      run_fault = ErrStuck;
    end else if (at_ref && (cnt_next != PeriodW)) begin
      run_fault = ErrShort;
    end else if (!at_ref && (cnt_next == PeriodW)) begin
      run_fault = ErrLong;
    end else if (CHECK_TICK && (bus.max_tick != at_ref)) begin
      run_fault = ErrTick;
    end
  end

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    period_ok_d  = period_ok_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    period_cnt_d = period_cnt_q;
    pass_cnt_d   = pass_cnt_q;

    if (bus.clear) begin
      state_d      = StIdle;
      ref_d        = '0;
      prev_d       = '0;
      cnt_d        = '0;
      period_ok_d  = 1'b0;
      err_d        = 1'b0;
      err_code_d   = ErrNone;
      period_cnt_d = '0;
      pass_cnt_d   = '0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.lfsr_q == LOCKUP) begin
            state_d     = StFail;
            err_d       = 1'b1;
            err_code_d  = ErrLockup;
            period_ok_d = 1'b0;
          end else begin
            // max_tick is meaningless on the capture sample.
            state_d = StRun;
            ref_d   = bus.lfsr_q;
            prev_d  = bus.lfsr_q;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (run_fault != ErrNone) begin
            state_d     = StFail;
            err_d       = 1'b1;
            err_code_d  = run_fault;
            period_ok_d = 1'b0;
            if (run_fault == ErrShort) begin
              period_cnt_d = cnt_next;
            end
          end else if (at_ref) begin
            // Fault-free return to the reference exactly at PERIOD.
            period_cnt_d = PeriodW;
            cnt_d        = '0;
            period_ok_d  = 1'b1;
            if (pass_cnt_q != 8'hFF) begin
              pass_cnt_d = pass_cnt_q + 8'd1;
            end
          end else begin
            cnt_d  = cnt_next;
            prev_d = bus.lfsr_q;
          end
        end
        StFail: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ref_q        <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      period_ok_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ErrNone;
      period_cnt_q <= '0;
      pass_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      period_ok_q  <= period_ok_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      period_cnt_q <= period_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
    end
  end

  assign bus.period_ok  = period_ok_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.busy       = (state_q == StRun);

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Randomised self-checking bench for lfsr_period_checker. Three instances:
// 12-bit with tick checking (a), 12-bit without (b, same stimulus as a), and a
// 4-bit/15-period instance (c). Each is compared every cycle with a reference
// model computed straight from the measurement rules.
module tb_lfsr_period_checker;

  localparam logic [11:0] Seed12 = 12'h367;
  localparam logic [3:0]  Seed4  = 4'h3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_period_checker_if #(.WIDTH(12)) bus_a ();
  lfsr_period_checker_if #(.WIDTH(12)) bus_b ();
  lfsr_period_checker_if #(.WIDTH(4))  bus_c ();

  lfsr_period_checker #(
    .WIDTH(12), .PERIOD(4095), .LOCKUP(12'hFFF), .CHECK_TICK(1'b1)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  lfsr_period_checker #(
    .WIDTH(12), .PERIOD(4095), .LOCKUP(12'hFFF), .CHECK_TICK(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  lfsr_period_checker #(
    .WIDTH(4), .PERIOD(15), .LOCKUP(4'hF), .CHECK_TICK(1'b1)
  ) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  int n_checks = 0;
  int n_pass   = 0;

  // phase: 0 waiting for reference, 1 measuring, 2 faulted
  typedef struct {
    int phase;
    int rf;
    int prev;
    int cnt;
    int ok;
    int err;
    int code;
    int pcnt;
    int pass;
  } mdl_t;

  mdl_t ma, mb, mc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m_in, int v, bit tk, int period, int lockup, bit chk);
    mdl_t m = m_in;
    int   n;
    int   code;
    bit   back;
    if (m.phase == 0) begin
      if (v == lockup) begin
        m.phase = 2; m.err = 1; m.code = 1; m.ok = 0;
      end else begin
        m.phase = 1; m.rf = v; m.prev = v; m.cnt = 0;
      end
    end else if (m.phase == 1) begin
      n    = m.cnt + 1;
      back = (v == m.rf);
      code = 0;
      if (v == lockup)                 code = 1;
      else if (v == m.prev)            code = 2;
      else if (back && n != period)    code = 3;
      else if (!back && n == period)   code = 4;
      else if (chk && (tk != back))    code = 5;
      if (code != 0) begin
        m.phase = 2; m.err = 1; m.code = code; m.ok = 0;
        if (code == 3) m.pcnt = n;
      end else if (back) begin
        m.pcnt = period; m.cnt = 0; m.ok = 1;
        m.pass = (m.pass < 255) ? m.pass + 1 : 255;
      end else begin
        m.cnt = n; m.prev = v;
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] mdl_out(mdl_t m);
    return {6'b0, m.ok[0], m.err[0], 3'(m.code), 12'(m.pcnt), 8'(m.pass), m.phase == 1};
  endfunction

  function automatic logic [11:0] lfsr12_next(logic [11:0] s);
    return {s[10:0], ~(s[11] ^ s[5] ^ s[3] ^ s[0])};
  endfunction

  function automatic logic [3:0] lfsr4_next(logic [3:0] s);
    return {s[2:0], ~(s[3] ^ s[2])};
  endfunction

  task automatic cmp_all(input string tag);
    check_eq({tag, "_a"}, {6'b0, bus_a.period_ok, bus_a.err, bus_a.err_code, bus_a.period_cnt,
                           bus_a.pass_cnt, bus_a.busy}, mdl_out(ma));
    check_eq({tag, "_b"}, {6'b0, bus_b.period_ok, bus_b.err, bus_b.err_code, bus_b.period_cnt,
                           bus_b.pass_cnt, bus_b.busy}, mdl_out(mb));
    check_eq({tag, "_c"}, {6'b0, bus_c.period_ok, bus_c.err, bus_c.err_code, 8'b0,
                           bus_c.period_cnt, bus_c.pass_cnt, bus_c.busy}, mdl_out(mc));
  endtask

  // One cycle on the two 12-bit checkers; outputs compared 1 time unit after the edge.
  task automatic step12(input logic [11:0] v, input logic tk, input logic vld, input logic clr);
    @(negedge clk);
    bus_a.lfsr_q = v; bus_a.max_tick = tk; bus_a.in_valid = vld; bus_a.clear = clr;
    bus_b.lfsr_q = v; bus_b.max_tick = tk; bus_b.in_valid = vld; bus_b.clear = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      ma = mdl_clear(); mb = mdl_clear();
    end else if (vld) begin
      ma = mdl_step(ma, int'(v), tk, 4095, 12'hFFF, 1'b1);
      mb = mdl_step(mb, int'(v), tk, 4095, 12'hFFF, 1'b0);
    end
    check_eq("a", {6'b0, bus_a.period_ok, bus_a.err, bus_a.err_code, bus_a.period_cnt,
                   bus_a.pass_cnt, bus_a.busy}, mdl_out(ma));
    check_eq("b", {6'b0, bus_b.period_ok, bus_b.err, bus_b.err_code, bus_b.period_cnt,
                   bus_b.pass_cnt, bus_b.busy}, mdl_out(mb));
    bus_a.in_valid = 1'b0; bus_a.clear = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.clear = 1'b0;
  endtask

  task automatic step4(input logic [3:0] v, input logic tk, input logic vld, input logic clr);
    @(negedge clk);
    bus_c.lfsr_q = v; bus_c.max_tick = tk; bus_c.in_valid = vld; bus_c.clear = clr;
    @(posedge clk);
    #1;
    if (clr) mc = mdl_clear();
    else if (vld) mc = mdl_step(mc, int'(v), tk, 15, 15, 1'b1);
    check_eq("c", {6'b0, bus_c.period_ok, bus_c.err, bus_c.err_code, 8'b0, bus_c.period_cnt,
                   bus_c.pass_cnt, bus_c.busy}, mdl_out(mc));
    bus_c.in_valid = 1'b0; bus_c.clear = 1'b0;
  endtask

  initial begin
    logic [11:0] s;
    logic [3:0]  s4;
    int          pos;
    int          stop;

    bus_a.clear = 0; bus_a.in_valid = 0; bus_a.lfsr_q = '0; bus_a.max_tick = 0;
    bus_b.clear = 0; bus_b.in_valid = 0; bus_b.lfsr_q = '0; bus_b.max_tick = 0;
    bus_c.clear = 0; bus_c.in_valid = 0; bus_c.lfsr_q = '0; bus_c.max_tick = 0;
    reset = 1'b1;
    ma = mdl_clear(); mb = mdl_clear(); mc = mdl_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    cmp_all("reset");

    // 1: golden stream, two full periods back to back.
    s = Seed12;
    step12(s, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 8191; i++) begin
      s = lfsr12_next(s);
      step12(s, s == Seed12, 1'b1, 1'b0);
      if (i == 4095) begin
        check_eq("s1_pcnt", 32'(bus_a.period_cnt), 32'd4095);
        check_eq("s1_pass1", 32'(bus_a.pass_cnt), 32'd1);
        check_eq("s1_ok", 32'(bus_a.period_ok), 32'd1);
      end
    end
    check_eq("s1_pass2", 32'(bus_a.pass_cnt), 32'd2);
    check_eq("s1_busy", {bus_a.err, bus_a.busy}, 32'b01);

    // 2: same stream with stall cycles carrying junk between samples.
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    s = Seed12;
    step12(s, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4097; i++) begin
      repeat ($urandom_range(1, 2)) step12(12'($urandom), 1'($urandom), 1'b0, 1'b0);
      s = lfsr12_next(s);
      step12(s, s == Seed12, 1'b1, 1'b0);
    end
    check_eq("s2_pcnt", 32'(bus_a.period_cnt), 32'd4095);
    check_eq("s2_pass", {bus_a.err, bus_a.pass_cnt}, 32'd1);

    // 3: lockup on the capture sample, then stuck.
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    step12(12'hFFF, 1'b0, 1'b1, 1'b0);
    check_eq("s3_lock", {bus_a.err, bus_a.err_code, bus_a.busy}, {27'b0, 1'b1, 3'd1, 1'b0});
    repeat (5) step12(12'($urandom), 1'($urandom), 1'b1, 1'b0);
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    step12(12'h456, 1'b0, 1'b1, 1'b0);
    step12(12'h123, 1'b0, 1'b1, 1'b0);
    step12(12'h123, 1'b0, 1'b1, 1'b0);
    check_eq("s3_stuck", 32'(bus_a.err_code), 32'd2);

    // 4: short period (back at ref on the 10th sample), then long period.
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    s = Seed12;
    step12(s, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      s = lfsr12_next(s);
      step12(s, 1'b0, 1'b1, 1'b0);
    end
    step12(Seed12, 1'b1, 1'b1, 1'b0);
    check_eq("s4_short", {bus_a.err_code, bus_a.period_cnt}, {17'b0, 3'd3, 12'd10});
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    step12(12'h800, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4095; i++) begin
      step12((i % 2 == 1) ? 12'h001 : 12'h002, 1'b0, 1'b1, 1'b0);
    end
    check_eq("s4_long", {bus_a.err_code, bus_a.period_cnt}, {17'b0, 3'd4, 12'd0});

    // 5: spurious max_tick at a random sample; only the tick-checking instance faults.
    step12(12'h000, 1'b0, 1'b1, 1'b1);
    pos  = $urandom_range(5, 2000);
    stop = pos + 3;
    s    = Seed12;
    step12(s, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= stop; i++) begin
      s = lfsr12_next(s);
      step12(s, (s == Seed12) || (i == pos), 1'b1, 1'b0);
    end
    check_eq("s5_tick_a", 32'(bus_a.err_code), 32'd5);
    check_eq("s5_tick_b", {bus_b.err, bus_b.busy}, 32'b01);

    // 6: 4-bit instance, saturation, clear mid-period, async reset mid-run.
    s4 = Seed4;
    step4(s4, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 260 * 15; i++) begin
      s4 = lfsr4_next(s4);
      step4(s4, s4 == Seed4, 1'b1, 1'b0);
    end
    check_eq("s6_sat", {bus_c.err, bus_c.period_cnt, bus_c.pass_cnt}, {19'b0, 4'd15, 8'd255});
    pos = $urandom_range(1, 12);
    for (int i = 0; i < pos; i++) begin
      s4 = lfsr4_next(s4);
      step4(s4, s4 == Seed4, 1'b1, 1'b0);
    end
    step4(4'h5, 1'b0, 1'b1, 1'b1);
    check_eq("s6_clear", {bus_c.period_ok, bus_c.pass_cnt, bus_c.busy}, 32'd0);
    s4 = lfsr4_next(s4);
    step4(s4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step4(lfsr4_next(s4), lfsr4_next(s4) == mc.rf[3:0], 1'b1, 1'b0);
      s4 = lfsr4_next(s4);
    end
    check_eq("s6_recap", {bus_c.err, bus_c.pass_cnt, bus_c.busy}, {23'b0, 8'd1, 1'b1});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    ma = mdl_clear(); mb = mdl_clear(); mc = mdl_clear();
    cmp_all("async");
    @(negedge clk);
    reset = 1'b0;
    step4(4'h9, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
